// File: rtl/mc_ctrl_unit.sv
// Multicycle RV32I control FSM: sequences FETCH/DECODE/EXE(/MEM/WB), bus timeout and sticky trap.
// Optional mul/div handshake states are built when MULDIV_EN is defined.
module mc_ctrl_unit #(
  parameter int MEM_WAIT_CYCLES = 1,
  parameter int BUS_TIMEOUT     = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [31:0] instrCode,
  input  logic       ready,
  input  logic       mdDone,
  output logic       PCEn,
  output logic       regFileWe,
  output logic       aluSrcMuxSel,
  output logic       busWe,
  output logic       branch,
  output logic       jal,
  output logic       jalr,
  output logic       transfer,
  output logic [3:0] aluControl,
  output logic [2:0] RFWDSrcMuxSel,
  output logic       mdStart,
  output logic       trap,
  output logic [1:0] trapCause
);
  localparam int TW = (BUS_TIMEOUT > 0) ? $clog2(BUS_TIMEOUT + 1) : 1;
  localparam int DW = (MEM_WAIT_CYCLES > 0) ? $clog2(MEM_WAIT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TO_LAST  = TW'(BUS_TIMEOUT - 1);
  localparam logic [DW-1:0] DLY_LAST = DW'(MEM_WAIT_CYCLES - 1);

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_B = 7'b1100011,
                         OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_S = 7'b0100011, OP_L = 7'b0000011;

  typedef enum logic [4:0] {
    FETCH, DECODE, R_EXE, I_EXE, B_EXE, LU_EXE, AU_EXE, J_EXE, JL_EXE,
    S_EXE, S_MEM, L_EXE, L_MEM, L_WB, MEM_DELAY, TRAP
`ifdef MULDIV_EN
    , MD_START, MD_WAIT, MD_WB
`endif
  } state_t;

  state_t state, next;
  logic [TW-1:0] to_cnt;
  logic [DW-1:0] dly_cnt;
  logic [1:0]    next_cause;
  logic          to_hit;

  wire [6:0] op  = instrCode[6:0];
  wire [2:0] f3  = instrCode[14:12];
  wire       i30 = instrCode[30];
  logic unused_bits;
  assign unused_bits = &{1'b0, instrCode, mdDone};

  // Timeout fires on the BUS_TIMEOUT-th consecutive low-ready cycle; ready=1 always completes.
  assign to_hit = (BUS_TIMEOUT != 0) && !ready && (to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= FETCH;
      to_cnt    <= '0;
      dly_cnt   <= '0;
      trapCause <= 2'b00;
    end else begin
      state <= next;
      if (state == S_MEM || state == L_MEM) begin
        if (!ready) to_cnt <= to_cnt + 1'b1;
      end else begin
        to_cnt <= '0;
      end
      if (state == MEM_DELAY) dly_cnt <= dly_cnt + 1'b1;
      else                    dly_cnt <= '0;
      if (state != TRAP && next == TRAP) trapCause <= next_cause;
    end
  end

  always_comb begin
    next          = state;
    next_cause    = 2'b00;
    PCEn          = 1'b0;
    regFileWe     = 1'b0;
    aluSrcMuxSel  = 1'b0;
    busWe         = 1'b0;
    branch        = 1'b0;
    jal           = 1'b0;
    jalr          = 1'b0;
    transfer      = 1'b0;
    aluControl    = 4'b0000;
    RFWDSrcMuxSel = 3'b000;
    mdStart       = 1'b0;
    trap          = 1'b0;
    case (state)
      FETCH: begin
        PCEn = 1'b1;
        next = DECODE;
      end
      DECODE: begin
        case (op)
`ifdef MULDIV_EN
          OP_R:     next = (instrCode[31:25] == 7'b0000001) ? MD_START : R_EXE;
`else
          OP_R:     next = R_EXE;
`endif
          OP_I:     next = I_EXE;
          OP_B:     next = B_EXE;
          OP_LUI:   next = LU_EXE;
          OP_AUIPC: next = AU_EXE;
          OP_JAL:   next = J_EXE;
          OP_JALR:  next = JL_EXE;
          OP_S:     next = S_EXE;
          OP_L:     next = L_EXE;
          default: begin
            next       = TRAP;
            next_cause = 2'b01;
          end
        endcase
      end
      R_EXE: begin
        regFileWe  = 1'b1;
        aluControl = {i30, f3};
        next       = FETCH;
      end
      I_EXE: begin
        // Only srai keeps bit 30; for other immediates it is just an immediate bit.
        regFileWe    = 1'b1;
        aluSrcMuxSel = 1'b1;
        aluControl   = ({i30, f3} == 4'b1101) ? 4'b1101 : {1'b0, f3};
        next         = FETCH;
      end
      B_EXE: begin
        branch     = 1'b1;
        aluControl = {i30, f3};
        next       = FETCH;
      end
      LU_EXE: begin
        regFileWe     = 1'b1;
        RFWDSrcMuxSel = 3'b010;
        next          = FETCH;
      end
      AU_EXE: begin
        regFileWe     = 1'b1;
        RFWDSrcMuxSel = 3'b011;
        next          = FETCH;
      end
      J_EXE: begin
        regFileWe     = 1'b1;
        RFWDSrcMuxSel = 3'b100;
        jal           = 1'b1;
        next          = FETCH;
      end
      JL_EXE: begin
        regFileWe     = 1'b1;
        RFWDSrcMuxSel = 3'b100;
        jal           = 1'b1;
        jalr          = 1'b1;
        next          = FETCH;
      end
      S_EXE: begin
        aluSrcMuxSel = 1'b1;
        next         = S_MEM;
      end
      S_MEM: begin
        aluSrcMuxSel = 1'b1;
        busWe        = 1'b1;
        transfer     = 1'b1;
        if (ready) next = (MEM_WAIT_CYCLES == 0) ? FETCH : MEM_DELAY;
        else if (to_hit) begin
          next       = TRAP;
          next_cause = 2'b10;
        end
      end
      L_EXE: begin
        aluSrcMuxSel  = 1'b1;
        RFWDSrcMuxSel = 3'b001;
        next          = L_MEM;
      end
      L_MEM: begin
        aluSrcMuxSel  = 1'b1;
        RFWDSrcMuxSel = 3'b001;
        transfer      = 1'b1;
        if (ready) next = L_WB;
        else if (to_hit) begin
          next       = TRAP;
          next_cause = 2'b10;
        end
      end
      L_WB: begin
        regFileWe     = 1'b1;
        aluSrcMuxSel  = 1'b1;
        RFWDSrcMuxSel = 3'b001;
        next          = (MEM_WAIT_CYCLES == 0) ? FETCH : MEM_DELAY;
      end
      MEM_DELAY: begin
        if (dly_cnt == DLY_LAST) next = FETCH;
      end
      TRAP: begin
        trap = 1'b1;
      end
`ifdef MULDIV_EN
      MD_START: begin
        mdStart = 1'b1;
        next    = MD_WAIT;
      end
      MD_WAIT: begin
        if (mdDone) next = MD_WB;
      end
      MD_WB: begin
        regFileWe     = 1'b1;
        RFWDSrcMuxSel = 3'b101;
        next          = FETCH;
      end
`endif
      default: next = FETCH;
    endcase
  end
endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Scoreboard bench for mc_ctrl_unit: stimulus queues expected per-cycle control vectors,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_mc_ctrl_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instrCode;
  logic        ready, mdDone;
  logic        PCEn, regFileWe, aluSrcMuxSel, busWe, branch, jal, jalr, transfer;
  logic [3:0]  aluControl;
  logic [2:0]  RFWDSrcMuxSel;
  logic        mdStart, trap;
  logic [1:0]  trapCause;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mc_ctrl_unit #(.MEM_WAIT_CYCLES(2), .BUS_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .instrCode(instrCode), .ready(ready), .mdDone(mdDone),
    .PCEn(PCEn), .regFileWe(regFileWe), .aluSrcMuxSel(aluSrcMuxSel), .busWe(busWe),
    .branch(branch), .jal(jal), .jalr(jalr), .transfer(transfer), .aluControl(aluControl),
    .RFWDSrcMuxSel(RFWDSrcMuxSel), .mdStart(mdStart), .trap(trap), .trapCause(trapCause)
  );

  // control bit order: PCEn regFileWe aluSrc busWe branch jal jalr transfer mdStart
  localparam logic [8:0] C_F  = 9'b100000000, C_Z   = 9'b000000000, C_WE = 9'b010000000,
                         C_I  = 9'b011000000, C_B   = 9'b000010000, C_J  = 9'b010001000,
                         C_JL = 9'b010001100, C_AS  = 9'b001000000, C_SM = 9'b001100010,
                         C_LM = 9'b001000010, C_MD  = 9'b000000001;

  function automatic logic [18:0] ev(input logic [8:0] c, input logic [3:0] alu,
                                     input logic [2:0] rf, input logic tp, input logic [1:0] tc);
    return {tp, tc, c, alu, rf};
  endfunction

  localparam logic [18:0] V_F = {1'b0, 2'b00, C_F, 4'b0000, 3'b000};
  localparam logic [18:0] V_Z = 19'd0;

  wire [18:0] act = {trap, trapCause, PCEn, regFileWe, aluSrcMuxSel, busWe, branch, jal, jalr,
                     transfer, mdStart, aluControl, RFWDSrcMuxSel};

  logic [18:0] sb_exp[$];
  string       sb_nm[$];

  task automatic chk(input logic [18:0] e, input string nm);
    total++;
    if (act !== e) begin
      bad++;
      $display("FAIL %s: got %b want %b (trap,cause,pc,we,as,bw,br,jal,jalr,tr,md,alu,rf)",
               nm, act, e);
    end
  endtask

  always @(negedge clk) begin
    if (sb_exp.size() != 0) chk(sb_exp.pop_front(), sb_nm.pop_front());
  end

  task automatic push(input string nm, input logic [18:0] e);
    sb_exp.push_back(e);
    sb_nm.push_back(nm);
  endtask

  task automatic cyc(input logic r, input logic md, input string nm, input logic [18:0] e);
    @(posedge clk); #1;
    ready  = r;
    mdDone = md;
    push(nm, e);
  endtask

  task automatic fetch(input logic [31:0] ins, input string nm);
    @(posedge clk); #1;
    instrCode = ins;
    ready     = 1'b0;
    mdDone    = 1'b0;
    push(nm, V_F);
  endtask

  // Async reset lands mid-cycle and is checked immediately, then released into a fresh FETCH.
  task automatic do_reset(input logic [31:0] ins, input string nm);
    @(negedge clk); #2;
    reset = 1'b0;
    #1 chk(V_F, {nm, "_async"});
    @(posedge clk); #1;
    reset     = 1'b1;
    instrCode = ins;
    ready     = 1'b0;
    push({nm, "_F"}, V_F);
  endtask

  initial begin
    reset     = 1'b0;
    ready     = 1'b0;
    mdDone    = 1'b0;
    instrCode = 32'h002081B3;
    #1 chk(V_F, "reset_state");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    push("add_F", V_F);
    cyc(0, 0, "add_D", V_Z);
    cyc(0, 0, "add_EX", ev(C_WE, 4'b0000, 3'b000, 0, 2'b00));

    fetch(32'h402081B3, "sub_F");
    cyc(0, 0, "sub_D", V_Z);
    cyc(0, 0, "sub_EX", ev(C_WE, 4'b1000, 3'b000, 0, 2'b00));

    fetch(32'h4030D093, "srai_F");
    cyc(0, 0, "srai_D", V_Z);
    cyc(0, 0, "srai_EX", ev(C_I, 4'b1101, 3'b000, 0, 2'b00));

    fetch(32'hC0000093, "addi_i30_F");
    cyc(0, 0, "addi_i30_D", V_Z);
    cyc(0, 0, "addi_i30_EX", ev(C_I, 4'b0000, 3'b000, 0, 2'b00));

    fetch(32'h00209063, "bne_F");
    cyc(0, 0, "bne_D", V_Z);
    cyc(0, 0, "bne_EX", ev(C_B, 4'b0001, 3'b000, 0, 2'b00));

    fetch(32'h123450B7, "lui_F");
    cyc(0, 0, "lui_D", V_Z);
    cyc(0, 0, "lui_EX", ev(C_WE, 4'b0000, 3'b010, 0, 2'b00));

    fetch(32'h00001097, "auipc_F");
    cyc(0, 0, "auipc_D", V_Z);
    cyc(0, 0, "auipc_EX", ev(C_WE, 4'b0000, 3'b011, 0, 2'b00));

    fetch(32'h000000EF, "jal_F");
    cyc(0, 0, "jal_D", V_Z);
    cyc(0, 0, "jal_EX", ev(C_J, 4'b0000, 3'b100, 0, 2'b00));

    fetch(32'h000100E7, "jalr_F");
    cyc(0, 0, "jalr_D", V_Z);
    cyc(0, 0, "jalr_EX", ev(C_JL, 4'b0000, 3'b100, 0, 2'b00));

    fetch(32'h022081B3, "mul_F");
    cyc(0, 0, "mul_D", V_Z);
`ifdef MULDIV_EN
    cyc(0, 1, "mul_start", ev(C_MD, 4'b0000, 3'b000, 0, 2'b00));
    for (int i = 0; i < 4; i++) cyc(0, 0, "mul_wait", V_Z);
    cyc(0, 1, "mul_wait_done", V_Z);
    cyc(0, 0, "mul_wb", ev(C_WE, 4'b0000, 3'b101, 0, 2'b00));
`else
    cyc(0, 0, "mul_as_r", ev(C_WE, 4'b0000, 3'b000, 0, 2'b00));
`endif

    // load: ready low 3 cycles, completes exactly when the timeout count would have expired
    fetch(32'h00012083, "lw_F");
    cyc(0, 0, "lw_D", V_Z);
    cyc(0, 0, "lw_EXE", ev(C_AS, 4'b0000, 3'b001, 0, 2'b00));
    cyc(0, 0, "lw_mem0", ev(C_LM, 4'b0000, 3'b001, 0, 2'b00));
    cyc(0, 0, "lw_mem1", ev(C_LM, 4'b0000, 3'b001, 0, 2'b00));
    cyc(0, 0, "lw_mem2", ev(C_LM, 4'b0000, 3'b001, 0, 2'b00));
    cyc(1, 0, "lw_mem3", ev(C_LM, 4'b0000, 3'b001, 0, 2'b00));
    cyc(0, 0, "lw_wb", ev(C_I, 4'b0000, 3'b001, 0, 2'b00));
    cyc(0, 0, "lw_dly0", V_Z);
    cyc(0, 0, "lw_dly1", V_Z);

    fetch(32'h00112023, "sw_F");
    cyc(0, 0, "sw_D", V_Z);
    cyc(0, 0, "sw_EXE", ev(C_AS, 4'b0000, 3'b000, 0, 2'b00));
    cyc(1, 0, "sw_mem", ev(C_SM, 4'b0000, 3'b000, 0, 2'b00));
    cyc(0, 0, "sw_dly0", V_Z);
    cyc(0, 0, "sw_dly1", V_Z);

    fetch(32'h00012083, "lwr_F");
    cyc(0, 0, "lwr_D", V_Z);
    cyc(0, 0, "lwr_EXE", ev(C_AS, 4'b0000, 3'b001, 0, 2'b00));
    cyc(0, 0, "lwr_mem", ev(C_LM, 4'b0000, 3'b001, 0, 2'b00));
    do_reset(32'h002081B3, "rst_lmem");
    cyc(0, 0, "post_rst_D", V_Z);
    cyc(0, 0, "post_rst_EX", ev(C_WE, 4'b0000, 3'b000, 0, 2'b00));

    fetch(32'h00112023, "swto_F");
    cyc(0, 0, "swto_D", V_Z);
    cyc(0, 0, "swto_EXE", ev(C_AS, 4'b0000, 3'b000, 0, 2'b00));
    for (int i = 0; i < 4; i++) cyc(0, 0, "swto_mem", ev(C_SM, 4'b0000, 3'b000, 0, 2'b00));
    cyc(1, 0, "swto_trap0", ev(C_Z, 4'b0000, 3'b000, 1, 2'b10));
    cyc(0, 0, "swto_trap1", ev(C_Z, 4'b0000, 3'b000, 1, 2'b10));
    cyc(1, 0, "swto_trap2", ev(C_Z, 4'b0000, 3'b000, 1, 2'b10));

    do_reset(32'h0000007F, "rst_trap");
    cyc(1, 0, "ill_D", V_Z);
    cyc(1, 0, "ill_trap0", ev(C_Z, 4'b0000, 3'b000, 1, 2'b01));
    cyc(0, 0, "ill_trap1", ev(C_Z, 4'b0000, 3'b000, 1, 2'b01));
    cyc(1, 0, "ill_trap2", ev(C_Z, 4'b0000, 3'b000, 1, 2'b01));

    do_reset(32'h002081B3, "rst_ill");
    cyc(0, 0, "final_D", V_Z);
    cyc(0, 0, "final_EX", ev(C_WE, 4'b0000, 3'b000, 0, 2'b00));

    for (int i = 0; i < 10 && sb_exp.size() != 0; i++) @(posedge clk);
    total++;
    if (sb_exp.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", sb_exp.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
